// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised 4-word-instruction model-computer core.
// Each instruction is {dest, arg2, arg1, opcode} and retires in one clock.
// It adds valid/ready I/O with stalling, a single-step latch, a hardware
// stack, and a sticky fault state (overflow, underflow, illegal opcode).
//
// Handshake semantics (both ports): a word transfers on a rising clk edge
// where valid and ready are both high. The input side consumes in_data
// only in a cycle where in_ready is high. in_ready is asserted
// combinationally, and only in the cycle that retires an instruction
// reading selector 0x41. The output side holds out_data/out_valid stable
// until out_ready is seen high at a clock edge.
module cpu_core_param #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 6,
  parameter int RAM_DEPTH   = 256,
  parameter int STACK_DEPTH = 16,
  parameter int PC_STEP     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       step,
  output logic [DATA_W-1:0]          imem_addr,
  input  logic [4*DATA_W-1:0]        imem_data,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       halted,
  output logic                       fault,
  output logic [1:0]                 fault_code,
  output logic [DATA_W-1:0]          pc_mon,
  output logic [NUM_REGS*DATA_W-1:0] reg_mon
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int SP_AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W   = SP_AW + 1;
  localparam int RI_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [6:0] SEL_PC   = 7'h40;
  localparam logic [6:0] SEL_IN   = 7'h41;
  localparam logic [6:0] SEL_OUT  = 7'h42;
  localparam logic [6:0] SEL_RAM  = 7'h43;
  localparam logic [6:0] SEL_RAMA = 7'h44;
  localparam logic [6:0] SEL_STK  = 7'h45;

  typedef enum logic [1:0] {
    ST_EXEC  = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] rama;
  logic [SP_W-1:0]   sp;
  logic              pending;
  logic [DATA_W-1:0] regs      [NUM_REGS];
  logic [DATA_W-1:0] stack_mem [STACK_DEPTH];
  logic [DATA_W-1:0] ram       [RAM_DEPTH];

  // ---------------- instruction fields ----------------
  logic [DATA_W-1:0] f_op, f_a1, f_a2, f_dst;
  assign {f_dst, f_a2, f_a1, f_op} = imem_data;

  logic [7:0] op8;
  logic [4:0] op5;
  logic       imm1, imm2, is_cond;
  logic [6:0] sel1, sel2, seld;

  assign op8     = f_op[7:0];
  assign op5     = op8[4:0];
  assign imm1    = op8[7];
  assign imm2    = op8[6];
  assign is_cond = op8[5];
  assign sel1    = f_a1[6:0];
  assign sel2    = f_a2[6:0];
  assign seld    = f_dst[6:0];

  // Instruction class. Conditional branches ignore op bits 4:3.
  logic is_alu, is_cbr, is_call, is_ret, is_hlt, illegal;
  assign is_alu  = !is_cond && (op5 < 5'd8);
  assign is_call = !is_cond && (op5 == 5'h18);
  assign is_ret  = !is_cond && (op5 == 5'h19);
  assign is_hlt  = !is_cond && (op5 == 5'h1A);
  assign is_cbr  = is_cond && (op8[2:0] < 3'd6);
  assign illegal = !(is_alu || is_cbr || is_call || is_ret || is_hlt);

  // Which operands are actually read: NOT ignores arg2, CALL uses arg1 only,
  // RET and HALT read nothing (so they never pop or stall on input).
  logic use1, use2, rd1, rd2, pop1, pop2, rd_in, wr_out, push;
  assign use1   = is_alu || is_cbr || is_call;
  assign use2   = (is_alu && (op5 != 5'd4)) || is_cbr;
  assign rd1    = use1 && !imm1;
  assign rd2    = use2 && !imm2;
  assign pop1   = rd1 && (sel1 == SEL_STK);
  assign pop2   = rd2 && (sel2 == SEL_STK);
  assign rd_in  = (rd1 && (sel1 == SEL_IN)) || (rd2 && (sel2 == SEL_IN));
  assign wr_out = is_alu && (seld == SEL_OUT);
  assign push   = (is_alu && (seld == SEL_STK)) || is_call;

  // ---------------- stack bookkeeping ----------------
  // All pops happen before the (single) push, so the push lands at sp_mid.
  logic [SP_W-1:0]   npop, sp_mid;
  logic [SP_AW-1:0]  stk_i1, stk_i2, stk_wi;
  logic [DATA_W-1:0] stk_top, stk_nxt;
  logic              underflow, overflow;

  assign npop      = SP_W'(pop1) + SP_W'(pop2) + SP_W'(is_ret);
  assign sp_mid    = sp - npop;
  assign stk_i1    = SP_AW'(sp - SP_W'(1));
  assign stk_i2    = SP_AW'(sp - SP_W'(2));
  assign stk_wi    = SP_AW'(sp_mid);
  assign stk_top   = stack_mem[stk_i1];
  assign stk_nxt   = stack_mem[stk_i2];
  assign underflow = npop > sp;
  assign overflow  = push && (sp_mid == SP_W'(STACK_DEPTH));

  // ---------------- operand fetch ----------------
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] ram_rd;
  assign ram_idx = RAM_AW'(rama);
  assign ram_rd  = ram[ram_idx];

  function automatic logic [DATA_W-1:0] sel_read(
    input logic [6:0]        sel,
    input logic [DATA_W-1:0] reg_v,
    input logic [DATA_W-1:0] pc_v,
    input logic [DATA_W-1:0] in_v,
    input logic [DATA_W-1:0] ram_v,
    input logic [DATA_W-1:0] rama_v,
    input logic [DATA_W-1:0] stk_v
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (sel < 7'(NUM_REGS)) begin
      r = reg_v;
    end else begin
      case (sel)
        SEL_PC:   r = pc_v;
        SEL_IN:   r = in_v;
        SEL_RAM:  r = ram_v;
        SEL_RAMA: r = rama_v;
        SEL_STK:  r = stk_v;
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

  logic [DATA_W-1:0] a1_val, a2_val;
  assign a1_val = imm1 ? f_a1 :
                  sel_read(sel1, regs[sel1[RI_W-1:0]], pc, in_data, ram_rd, rama, stk_top);
  assign a2_val = imm2 ? f_a2 :
                  sel_read(sel2, regs[sel2[RI_W-1:0]], pc, in_data, ram_rd, rama,
                           pop1 ? stk_nxt : stk_top);

  // ALU result, modulo 2^DATA_W.
  logic [DATA_W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op5[2:0])
      3'd0:    alu_res = a1_val + a2_val;
      3'd1:    alu_res = a1_val - a2_val;
      3'd2:    alu_res = a1_val & a2_val;
      3'd3:    alu_res = a1_val | a2_val;
      3'd4:    alu_res = ~a1_val;
      3'd5:    alu_res = a1_val ^ a2_val;
      3'd6:    alu_res = a1_val << a2_val[2:0];
      default: alu_res = a1_val >> a2_val[2:0];
    endcase
  end

  // Unsigned branch condition.
  logic taken;
  always_comb begin
    taken = 1'b0;
    case (op8[2:0])
      3'd0:    taken = (a1_val == a2_val);
      3'd1:    taken = (a1_val != a2_val);
      3'd2:    taken = (a1_val <  a2_val);
      3'd3:    taken = (a1_val <= a2_val);
      3'd4:    taken = (a1_val >  a2_val);
      3'd5:    taken = (a1_val >= a2_val);
      default: taken = 1'b0;
    endcase
  end

  // ---------------- control ----------------
  logic [DATA_W-1:0] pc_inc, pc_nxt, push_val;
  logic              go, stall, bad, retire, take_fault;
  logic [1:0]        fcode_nxt;

  assign pc_inc     = pc + DATA_W'(PC_STEP);
  assign go         = !rst && (state == ST_EXEC) && (run || pending);
  assign stall      = (rd_in && !in_valid) || (wr_out && out_valid && !out_ready);
  assign bad        = illegal || underflow || overflow;
  assign retire     = go && !stall && !bad;
  assign take_fault = go && !stall && bad;
  assign in_ready   = retire && rd_in;
  assign push_val   = is_call ? pc_inc : alu_res;
  assign fcode_nxt  = illegal ? 2'd3 : (underflow ? 2'd2 : 2'd1);

  // Next program counter for a retiring instruction.
  always_comb begin
    pc_nxt = pc_inc;
    if (is_hlt)                              pc_nxt = pc;
    else if (is_alu && (seld == SEL_PC))     pc_nxt = alu_res;
    else if (is_cbr && taken)                pc_nxt = f_dst;
    else if (is_call)                        pc_nxt = a1_val;
    else if (is_ret)                         pc_nxt = stk_top;
  end

  // FSM, architectural registers, step latch and output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EXEC;
      pc         <= '0;
      rama       <= '0;
      sp         <= '0;
      pending    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      fault_code <= 2'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (step)        pending <= 1'b1;
      else if (retire) pending <= 1'b0;

      if (retire && wr_out) begin
        out_data  <= alu_res;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (take_fault) begin
        state      <= ST_FAULT;
        fault_code <= fcode_nxt;
      end

      if (retire) begin
        pc <= pc_nxt;
        sp <= sp_mid + SP_W'(push);
        if (is_hlt) state <= ST_HALT;
        if (is_alu) begin
          if (seld < 7'(NUM_REGS)) regs[seld[RI_W-1:0]] <= alu_res;
          if (seld == SEL_RAMA)    rama <= alu_res;
        end
      end
    end
  end

  // Stack and data RAM storage: contents are not reset.
  always_ff @(posedge clk) begin
    if (retire && push)                          stack_mem[stk_wi] <= push_val;
    if (retire && is_alu && (seld == SEL_RAM))   ram[ram_idx] <= alu_res;
  end

  assign imem_addr = pc;
  assign pc_mon    = pc;
  assign halted    = (state == ST_HALT);
  assign fault     = (state == ST_FAULT);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_mon
    assign reg_mon[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param: directed programs with hand-computed results.
// Values leaving the output port are checked by a scoreboard monitor.
module tb_cpu_core_param;
  localparam int W = 8;

  logic           clk, rst, run, step;
  logic [W-1:0]   imem_addr;
  logic [4*W-1:0] imem_data;
  logic [W-1:0]   in_data;
  logic           in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
  logic           halted, fault;
  logic [1:0]     fault_code;
  logic [W-1:0]   pc_mon;
  logic [6*W-1:0] reg_mon;

  cpu_core_param dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .fault(fault), .fault_code(fault_code),
    .pc_mon(pc_mon), .reg_mon(reg_mon)
  );

  // Instruction ROM: 64 words cover the whole 8-bit PC space at step 4.
  logic [4*W-1:0] imem [64];
  assign imem_data = imem[imem_addr[7:2]];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_chk = 0;
  int n_pass = 0;
  int in_rdy_cnt = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: each accepted output transfer is matched to the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(mon_exp));
      end
    end
    if (!rst && in_ready) in_rdy_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = {24'h0, 8'h1A};
  endtask

  task automatic put(input int addr, input logic [7:0] op, input logic [7:0] a1,
                     input logic [7:0] a2, input logic [7:0] d);
    imem[addr/4] = {d, a2, a1, op};
  endtask

  task automatic reset_dut();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    in_rdy_cnt = 0;
  endtask

  task automatic step_one();
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
  endtask

  task automatic run_until_stop(input string name, input int max);
    int n;
    n = 0;
    while (!halted && !fault && n < max) begin
      tick(1);
      n++;
    end
    chk(name, 64'(halted | fault), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] regv(input int i);
    return reg_mon[i*W +: W];
  endfunction

  logic [7:0] ill_ops [3];

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Basic ALU sequence and HALT.
    clear_prog();
    put(0, 8'h80, 8'h05, 8'h00, 8'h00);   // r0 = 5 + r0
    put(4, 8'hC1, 8'h03, 8'h0A, 8'h01);   // r1 = 3 - 10
    put(8, 8'h1A, 8'h00, 8'h00, 8'h00);   // HALT
    reset_dut();
    chk("reset_pc", 64'(pc_mon), 64'h0);
    chk("reset_regs", 64'(reg_mon), 64'h0);
    chk("reset_out_data", 64'(out_data), 64'h0);
    chk("reset_flags", 64'({out_valid, in_ready, halted, fault, fault_code}), 64'h0);
    run = 1'b1;
    tick(2);
    chk("basic_not_halted", 64'(halted), 64'd0);
    chk("basic_pc_2", 64'(pc_mon), 64'h08);
    tick(1);
    chk("basic_halted", 64'(halted), 64'd1);
    chk("basic_r0", 64'(regv(0)), 64'h05);
    chk("basic_r1", 64'(regv(1)), 64'hF9);
    tick(3);
    chk("basic_pc_hold", 64'(pc_mon), 64'h08);

    // Counting loop with conditional branch back.
    clear_prog();
    put(0,  8'h80, 8'h01, 8'h00, 8'h00);  // r0 = 1 + r0
    put(4,  8'h62, 8'h00, 8'h0A, 8'h00);  // if r0 < 10 goto 0
    put(8,  8'h40, 8'h00, 8'h00, 8'h42);  // out = r0 + 0
    reset_dut();
    exp_q.push_back(8'h0A);
    run = 1'b1;
    run_until_stop("loop_stop", 200);
    chk("loop_r0", 64'(regv(0)), 64'h0A);
    chk("loop_pc", 64'(pc_mon), 64'h0C);
    wait_drain("loop_drain");

    // Single-step and PC wrap past 0xFC.
    clear_prog();
    put(0,    8'hC0, 8'hF8, 8'h00, 8'h40); // jump to 0xF8
    put(8'hF8, 8'hC0, 8'h33, 8'h00, 8'h42); // out = 0x33
    put(8'hFC, 8'h80, 8'h01, 8'h00, 8'h00); // r0 = 1 + r0
    reset_dut();
    exp_q.push_back(8'h33);
    step_one();
    chk("step_pc_jump", 64'(pc_mon), 64'hF8);
    tick(2);
    chk("step_pc_idle", 64'(pc_mon), 64'hF8);
    step_one();
    step_one();
    chk("wrap_pc", 64'(pc_mon), 64'h00);
    chk("wrap_r0", 64'(regv(0)), 64'h01);
    wait_drain("step_drain");

    // Input stall.
    clear_prog();
    put(0, 8'h40, 8'h41, 8'h00, 8'h00);   // r0 = in + 0
    reset_dut();
    run = 1'b1;
    tick(4);
    chk("in_stall_pc", 64'(pc_mon), 64'h00);
    chk("in_stall_ready", 64'(in_ready), 64'd0);
    chk("in_stall_cnt", 64'(in_rdy_cnt), 64'd0);
    in_data = 8'h37;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    chk("in_r0", 64'(regv(0)), 64'h37);
    chk("in_ready_once", 64'(in_rdy_cnt), 64'd1);
    chk("in_pc", 64'(pc_mon), 64'h04);

    // Output stall and drain.
    clear_prog();
    put(0, 8'hC0, 8'hA1, 8'h00, 8'h42);
    put(4, 8'hC0, 8'hB2, 8'h00, 8'h42);
    reset_dut();
    out_ready = 1'b0;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB2);
    run = 1'b1;
    tick(3);
    chk("out_stall_pc", 64'(pc_mon), 64'h04);
    chk("out_stall_data", 64'(out_data), 64'hA1);
    chk("out_stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("out_second_data", 64'(out_data), 64'hB2);
    chk("out_second_valid", 64'(out_valid), 64'd1);
    chk("out_second_pc", 64'(pc_mon), 64'h08);
    tick(1);
    chk("out_halted", 64'(halted), 64'd1);
    out_ready = 1'b1;
    wait_drain("out_drain");

    // CALL / RET.
    clear_prog();
    put(0,    8'h98, 8'h20, 8'h00, 8'h00); // CALL 0x20
    put(4,    8'hC0, 8'h5A, 8'h00, 8'h42); // out = 0x5A
    put(8'h20, 8'hC0, 8'h11, 8'h00, 8'h02); // r2 = 0x11
    put(8'h24, 8'h19, 8'h00, 8'h00, 8'h00); // RET
    reset_dut();
    exp_q.push_back(8'h5A);
    run = 1'b1;
    run_until_stop("call_stop", 30);
    chk("call_pc", 64'(pc_mon), 64'h08);
    chk("call_r2", 64'(regv(2)), 64'h11);
    chk("call_no_fault", 64'(fault), 64'd0);
    wait_drain("call_drain");

    // Pop order, then underflow.
    clear_prog();
    put(0,  8'hC0, 8'h55, 8'h00, 8'h45);
    put(4,  8'hC0, 8'h0A, 8'h00, 8'h45);
    put(8,  8'hC0, 8'h03, 8'h00, 8'h45);
    put(12, 8'h01, 8'h45, 8'h45, 8'h03);  // r3 = pop - pop
    put(16, 8'h40, 8'h45, 8'h00, 8'h42);  // out = pop
    put(20, 8'h40, 8'h45, 8'h00, 8'h04);  // r4 = pop (empty)
    reset_dut();
    exp_q.push_back(8'h55);
    run = 1'b1;
    run_until_stop("uf_stop", 30);
    chk("uf_r3", 64'(regv(3)), 64'hF9);
    chk("uf_fault", 64'({fault, fault_code}), 64'b110);
    chk("uf_pc", 64'(pc_mon), 64'd20);
    chk("uf_r4", 64'(regv(4)), 64'h00);
    wait_drain("uf_drain");

    // 17 pushes into a 16-deep stack, then asynchronous reset out of FAULT.
    clear_prog();
    for (int i = 0; i < 17; i++) put(i*4, 8'hC0, 8'(i + 1), 8'h00, 8'h45);
    reset_dut();
    run = 1'b1;
    run_until_stop("of_stop", 40);
    chk("of_fault", 64'({fault, fault_code}), 64'b101);
    chk("of_pc", 64'(pc_mon), 64'd64);
    chk("of_not_halted", 64'(halted), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("of_async_rst", 64'({fault, fault_code, halted}), 64'h0);
    chk("of_async_pc", 64'(pc_mon), 64'h0);

    // Illegal opcodes.
    ill_ops[0] = 8'h1F;
    ill_ops[1] = 8'h27;
    ill_ops[2] = 8'h08;
    for (int k = 0; k < 3; k++) begin
      clear_prog();
      put(0, 8'h80, 8'h01, 8'h00, 8'h00);
      put(4, ill_ops[k], 8'h00, 8'h00, 8'h00);
      reset_dut();
      run = 1'b1;
      run_until_stop("ill_stop", 10);
      chk($sformatf("ill_code_%0h", ill_ops[k]), 64'({fault, fault_code}), 64'b111);
      chk($sformatf("ill_pc_%0h", ill_ops[k]), 64'(pc_mon), 64'h04);
      chk($sformatf("ill_r0_%0h", ill_ops[k]), 64'(regv(0)), 64'h01);
    end

    // Reset asserted mid output stall: pending output is lost at once.
    clear_prog();
    put(0, 8'hC0, 8'hC3, 8'h00, 8'h42);
    put(4, 8'hC0, 8'hD4, 8'h00, 8'h42);
    reset_dut();
    out_ready = 1'b0;
    run = 1'b1;
    tick(3);
    chk("rst_stall_pc", 64'(pc_mon), 64'h04);
    chk("rst_stall_valid", 64'(out_valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_out", 64'({out_valid, out_data}), 64'h0);
    chk("rst_async_state", 64'({pc_mon, in_ready, halted, fault, fault_code}), 64'h0);
    chk("rst_async_regs", 64'(reg_mon), 64'h0);
    tick(2);
    rst = 1'b0;
    run = 1'b0;

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
